// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits LSB-first, optional parity, stop bit(s).
// Accepts bytes over valid/ready; a one-entry holding buffer allows gapless frames.
//
// Ports:
//   clkTx        transmit clock, rising edge
//   rstN         asynchronous active-low reset
//   txData       byte to send, sampled when txValid && txReady
//   txValid      source has a byte
//   txReady      holding buffer empty
//   serialOutput registered serial line, idle high
//   txBusy       a frame is on the line
//   txDone       one-cycle pulse when the last stop bit completes
module uart_tx #(
    parameter int clocksPerBit = 87,
    parameter int parityMode   = 0,
    parameter int stopBits     = 1
) (
    input  logic       clkTx,
    input  logic       rstN,
    input  logic [7:0] txData,
    input  logic       txValid,
    output logic       txReady,
    output logic       serialOutput,
    output logic       txBusy,
    output logic       txDone
);

    localparam int BitCntW  = $clog2(clocksPerBit);
    localparam int StopCntW = $clog2(2 * clocksPerBit);

    localparam logic [BitCntW-1:0]  bitLast  = BitCntW'(clocksPerBit - 1);
    localparam logic [StopCntW-1:0] stopLast = StopCntW'(stopBits * clocksPerBit - 1);
    localparam logic [BitCntW-1:0]  bitOne   = BitCntW'(1);
    localparam logic [StopCntW-1:0] stopOne  = StopCntW'(1);
    localparam logic                oddSel   = (parityMode == 2);
    localparam logic                hasParity = (parityMode != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txStateT;

    txStateT             state, stateNext;
    logic [BitCntW-1:0]  bitCnt, bitCntNext;
    logic [StopCntW-1:0] stopCnt, stopCntNext;
    logic [2:0]          bitIndex, bitIndexNext;
    logic [7:0]          shiftReg, shiftNext;
    logic [7:0]          holdBuf, holdBufNext;
    logic                bufFull, bufFullNext;
    logic                lineNext;
    logic                doneNext;
    logic                accept;
    logic                stopEnd;

    assign txReady = !bufFull;
    assign txBusy  = (state != IDLE);
    assign accept  = txValid && txReady;
    assign stopEnd = (state == STOP) && (stopCnt == stopLast);

    always_ff @(posedge clkTx or negedge rstN) begin
        if (!rstN) begin
            state        <= IDLE;
            bitCnt       <= '0;
            stopCnt      <= '0;
            bitIndex     <= '0;
            shiftReg     <= '0;
            holdBuf      <= '0;
            bufFull      <= 1'b0;
            serialOutput <= 1'b1;
            txDone       <= 1'b0;
        end else begin
            state        <= stateNext;
            bitCnt       <= bitCntNext;
            stopCnt      <= stopCntNext;
            bitIndex     <= bitIndexNext;
            shiftReg     <= shiftNext;
            holdBuf      <= holdBufNext;
            bufFull      <= bufFullNext;
            serialOutput <= lineNext;
            txDone       <= doneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        bitCntNext   = bitCnt;
        stopCntNext  = stopCnt;
        bitIndexNext = bitIndex;
        shiftNext    = shiftReg;
        holdBufNext  = holdBuf;
        bufFullNext  = bufFull;
        doneNext     = 1'b0;
        lineNext     = 1'b1;

        // Mid-frame bytes wait in the buffer; at the stop-end edge an
        // accepted byte is loaded straight into the shifter instead.
        if (accept && (state != IDLE) && !stopEnd) begin
            holdBufNext = txData;
            bufFullNext = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    shiftNext  = txData;
                    bitCntNext = '0;
                    stateNext  = START;
                end
            end
            START: begin
                if (bitCnt == bitLast) begin
                    bitCntNext   = '0;
                    bitIndexNext = '0;
                    stateNext    = DATA;
                end else begin
                    bitCntNext = bitCnt + bitOne;
                end
            end
            DATA: begin
                if (bitCnt == bitLast) begin
                    bitCntNext = '0;
                    if (bitIndex == 3'd7) begin
                        stopCntNext = '0;
                        stateNext   = hasParity ? PARITY : STOP;
                    end else begin
                        bitIndexNext = bitIndex + 3'd1;
                    end
                end else begin
                    bitCntNext = bitCnt + bitOne;
                end
            end
            PARITY: begin
                if (bitCnt == bitLast) begin
                    bitCntNext  = '0;
                    stopCntNext = '0;
                    stateNext   = STOP;
                end else begin
                    bitCntNext = bitCnt + bitOne;
                end
            end
            STOP: begin
                if (stopEnd) begin
                    doneNext    = 1'b1;
                    stopCntNext = '0;
                    bitCntNext  = '0;
                    if (bufFull) begin
                        shiftNext   = holdBuf;
                        bufFullNext = 1'b0;
                        stateNext   = START;
                    end else if (accept) begin
                        shiftNext = txData;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    stopCntNext = stopCnt + stopOne;
                end
            end
            default: begin
                stateNext    = IDLE;
                bitCntNext   = '0;
                stopCntNext  = '0;
                bitIndexNext = '0;
                bufFullNext  = 1'b0;
            end
        endcase

        // The line register follows the state being entered, so each level
        // appears on the same edge that starts its bit period.
        unique case (stateNext)
            IDLE:    lineNext = 1'b1;
            START:   lineNext = 1'b0;
            DATA:    lineNext = shiftNext[bitIndexNext];
            PARITY:  lineNext = (^shiftNext) ^ oddSel;
            STOP:    lineNext = 1'b1;
            default: lineNext = 1'b1;
        endcase
    end

endmodule
